x_dl_scheduler: RTL and testbench



---
 rtl/x_dl_pkg.sv | 15 +
 rtl/x_dl_scheduler_popcount.sv | 18 +
 rtl/x_dl_scheduler.sv | 114 +++++++++++
 tb/tb_x_dl_scheduler.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/x_dl_pkg.sv
// Shared types and constants for the delay-line measurement sequencer.
package x_dl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FIRE    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } dl_state_t;

    localparam int C_PC_W = 6;
    localparam int C_TAPS = 32;

endpackage

// File: rtl/x_dl_scheduler_popcount.sv
// x_popcount: combinational ones-count of a tap word.
module x_popcount
    import x_dl_pkg::*;
#(
    parameter int P_TAPS = C_TAPS
) (
    input  logic [P_TAPS-1:0] i_dl,
    output logic [C_PC_W-1:0] o_cnt
);

    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < P_TAPS; i++) begin
            o_cnt = o_cnt + C_PC_W'(i_dl[i]);
        end
    end

endmodule

// File: rtl/x_dl_scheduler.sv
// Delay-line measurement sequencer: fires N start pulses, accumulates tap ones-counts.
// Optional thermometer-code checking is enabled with X_DL_SCHED_THERM_CHECK_EN.
module x_dl_scheduler
    import x_dl_pkg::*;
#(
    parameter int P_CNT_W  = 8,
    parameter int P_SETTLE = 4,
    parameter int P_TAPS   = C_TAPS
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_accept,
    input  logic [P_CNT_W-1:0]   i_cmd_count,
    output logic                 o_start,
    input  logic [P_TAPS-1:0]    i_dl,
    output logic                 o_res_valid,
    input  logic                 i_res_accept,
    output logic [P_CNT_W+5:0]   o_res_sum,
    output logic [C_PC_W-1:0]    o_res_min,
    output logic [C_PC_W-1:0]    o_res_max,
    output logic [P_CNT_W:0]     o_res_bad,
    output logic                 o_busy
);

    localparam int C_SET_W = (P_SETTLE < 2) ? 1 : $clog2(P_SETTLE);

    dl_state_t             r_state;
    logic [P_CNT_W:0]      r_remaining;
    logic [C_SET_W-1:0]    r_settle;
    logic [P_CNT_W+5:0]    r_sum;
    logic [C_PC_W-1:0]     r_min;
    logic [C_PC_W-1:0]     r_max;
    logic [C_PC_W-1:0]     w_pc;
    logic                  w_take;

    x_popcount #(.P_TAPS(P_TAPS)) u_popcount (
        .i_dl  (i_dl),
        .o_cnt (w_pc)
    );

    assign w_take = (r_state == ST_IDLE) && i_cmd_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_settle    <= '0;
            r_sum       <= '0;
            r_min       <= '0;
            r_max       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_cmd_valid) begin
                        r_state     <= ST_FIRE;
                        // zero count encodes the full 2^P_CNT_W burst
                        r_remaining <= (i_cmd_count == '0) ? {1'b1, {P_CNT_W{1'b0}}}
                                                           : {1'b0, i_cmd_count};
                        r_sum       <= '0;
                        r_min       <= C_PC_W'(P_TAPS);
                        r_max       <= '0;
                    end
                end
                ST_FIRE: begin
                    r_state  <= ST_SETTLE;
                    r_settle <= C_SET_W'(P_SETTLE - 1);
                end
                ST_SETTLE: begin
                    if (r_settle == '0) r_state <= ST_CAPTURE;
                    else                r_settle <= r_settle - 1'b1;
                end
                ST_CAPTURE: begin
                    r_sum       <= r_sum + (P_CNT_W+6)'(w_pc);
                    if (w_pc < r_min) r_min <= w_pc;
                    if (w_pc > r_max) r_max <= w_pc;
                    r_remaining <= r_remaining - 1'b1;
                    r_state     <= (r_remaining > 1) ? ST_FIRE : ST_DONE;
                end
                ST_DONE: begin
                    if (i_res_accept) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef X_DL_SCHED_THERM_CHECK_EN
    logic [P_CNT_W:0] r_bad;
    logic             w_not_therm;

    // thermometer words have no 0 below a 1, so adding one clears every set bit
    assign w_not_therm = (i_dl & (i_dl + P_TAPS'(1))) != '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                  r_bad <= '0;
        else if (w_take)                               r_bad <= '0;
        else if (r_state == ST_CAPTURE && w_not_therm) r_bad <= r_bad + 1'b1;
    end

    assign o_res_bad = r_bad;
`else
    assign o_res_bad = '0;
`endif

    assign o_cmd_accept = (r_state == ST_IDLE);
    assign o_start      = (r_state == ST_FIRE);
    assign o_res_valid  = (r_state == ST_DONE);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_res_sum    = r_sum;
    assign o_res_min    = r_min;
    assign o_res_max    = r_max;

endmodule

// File: tb/tb_x_dl_scheduler.sv
// Scoreboard bench for x_dl_scheduler: expected results queued at command time, checked on result.
module tb_x_dl_scheduler;

    localparam int P_CNT_W  = 8;
    localparam int P_SETTLE = 4;
    localparam int P_TAPS   = 32;
    localparam int PERIOD   = P_SETTLE + 2;

    typedef struct {
        int unsigned n;
        int unsigned sum;
        int unsigned mn;
        int unsigned mx;
        int unsigned bad;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_accept;
    logic [P_CNT_W-1:0]   cmd_count = '0;
    logic                 start;
    logic [P_TAPS-1:0]    dl = '0;
    logic                 res_valid;
    logic                 res_accept = 1'b0;
    logic [P_CNT_W+5:0]   res_sum;
    logic [5:0]           res_min;
    logic [5:0]           res_max;
    logic [P_CNT_W:0]     res_bad;
    logic                 busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_starts = 0;
    int last_start = 0;
    int gap_err = 0;

    logic [31:0] dl_q[$];
    logic [31:0] dl_def = '0;
    exp_t        exp_q[$];

    x_dl_scheduler #(.P_CNT_W(P_CNT_W), .P_SETTLE(P_SETTLE), .P_TAPS(P_TAPS)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_accept (cmd_accept),
        .i_cmd_count  (cmd_count),
        .o_start      (start),
        .i_dl         (dl),
        .o_res_valid  (res_valid),
        .i_res_accept (res_accept),
        .o_res_sum    (res_sum),
        .o_res_min    (res_min),
        .o_res_max    (res_max),
        .o_res_bad    (res_bad),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Each start pulse loads the tap word the following capture will sample.
    always @(negedge clk) begin
        if (start) begin
            if (n_starts > 0 && (cyc - last_start) != PERIOD) gap_err = gap_err + 1;
            last_start = cyc;
            n_starts   = n_starts + 1;
            dl = (dl_q.size() > 0) ? dl_q.pop_front() : dl_def;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic is_therm(input logic [31:0] v);
        int unsigned k;
        k = $countones(v);
        return (k == 0) ? (v == 0) : (v == (32'hFFFF_FFFF >> (32 - k)));
    endfunction

    task automatic push_exp(input int unsigned n);
        exp_t e;
        logic [31:0] v;
        e.n = n; e.sum = 0; e.mn = 32; e.mx = 0; e.bad = 0;
        for (int i = 0; i < int'(n); i++) begin
            v = (i < dl_q.size()) ? dl_q[i] : dl_def;
            e.sum += $countones(v);
            if ($countones(v) < e.mn) e.mn = $countones(v);
            if ($countones(v) > e.mx) e.mx = $countones(v);
`ifdef X_DL_SCHED_THERM_CHECK_EN
            if (!is_therm(v)) e.bad++;
`endif
        end
        exp_q.push_back(e);
    endtask

    // Issue one command, optionally harass the DUT while busy, then check the result.
    task automatic run_cmd(input int cnt, input bit spurious);
        int t;
        int k;
        int unsigned n;
        exp_t e;
        n = (cnt == 0) ? (1 << P_CNT_W) : cnt;
        @(negedge clk);
        n_starts = 0; gap_err = 0;
        push_exp(n);
        cmd_valid = 1'b1;
        cmd_count = P_CNT_W'(cnt);
        k = 0;
        while (!cmd_accept && k < 20) begin @(negedge clk); k++; end
        chk("cmd_accept", cmd_accept, 1);
        t = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (spurious) begin
            cmd_valid = 1'b1; res_accept = 1'b1;
            for (int i = 0; i < 8; i++) begin
                chk("busy_no_accept", cmd_accept, 0);
                @(negedge clk);
            end
            cmd_valid = 1'b0; res_accept = 1'b0;
        end
        k = 0;
        while (!res_valid && k < 4000) begin @(negedge clk); k++; end
        chk("res_valid", res_valid, 1);
        chk("res_latency", cyc, t + 1 + n * PERIOD);
        e = exp_q.pop_front();
        chk("sum", res_sum, e.sum);
        chk("min", res_min, e.mn);
        chk("max", res_max, e.mx);
        chk("bad", res_bad, e.bad);
        chk("starts", n_starts, e.n);
        chk("start_gap", gap_err, 0);
        res_accept = 1'b1;
        @(negedge clk);
        res_accept = 1'b0;
        chk("valid_drop", res_valid, 0);
        chk("sum_hold", res_sum, e.sum);
        chk("idle_accept", cmd_accept, 1);
        dl_q.delete();
    endtask

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_start", start, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_sum", res_sum, 0);
        chk("rst_min", res_min, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_cmd_accept", cmd_accept, 1);

        dl_def = 32'h0000_00FF;
        run_cmd(4, 0);

        dl_q = '{32'h0000_000F, 32'hFFFF_FFFF, 32'h0000_0000};
        run_cmd(3, 0);

        dl_def = 32'hFFFF_FFFF;
        run_cmd(0, 0);

        dl_def = 32'h0000_0FFF;
        run_cmd(2, 1);

        dl_q = '{32'h0000_00F0, 32'h0000_00FF};
        run_cmd(2, 0);

        // Reset during the third settle window of an 8-sample burst.
        dl_def = 32'h0000_0003;
        @(negedge clk);
        n_starts = 0;
        cmd_valid = 1'b1; cmd_count = 8'd8;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < 100 && n_starts < 3; k++) @(negedge clk);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_start", start, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_sum", res_sum, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dl_def = 32'h0000_003F;
        run_cmd(1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
